decay_tone_player: RTL and testbench

DECAY_TONE_PLAYER -- requirements
Module: decay_tone_player

---
 rtl/decay_tone_player.sv | 121 ++++++++++++
 tb/tb_decay_tone_player.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/decay_tone_player.sv
// Decaying-duty PWM tone effect: plays REPEATS passes of STAGES tone periods,
// shrinking the high time each period, with retrigger, abort and done pulse.
module decay_tone_player #(
  parameter int PERIOD_W    = 19,
  parameter int PERIOD      = 200000,
  parameter int STAGES      = 16,
  parameter int REPEATS     = 2,
  parameter int DUTY0       = 37878,
  parameter int DECAY_SHIFT = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic trigger,
  input  logic abort,
  output logic wave_out,
  output logic busy,
  output logic done
);

  typedef enum logic [1:0] {IDLE, PLAY, DONE} state_t;

  localparam logic [PERIOD_W-1:0] PERIOD_LAST = PERIOD_W'(PERIOD - 1);
  localparam logic [PERIOD_W-1:0] DUTY_INIT   = PERIOD_W'(DUTY0);
  localparam logic [PERIOD_W-1:0] ONE         = PERIOD_W'(1);
  localparam logic [7:0]          STAGE_LAST  = 8'(STAGES - 1);
  localparam logic [3:0]          PASS_LAST   = 4'(REPEATS - 1);

  state_t              state, state_nx;
  logic [PERIOD_W-1:0] counter, counter_nx;
  logic [PERIOD_W-1:0] duty, duty_nx;
  logic [7:0]          stage, stage_nx;
  logic [3:0]          pass, pass_nx;
  logic                wave_nx, busy_nx, done_nx;
  logic [PERIOD_W-1:0] decayed, duty_dec;

  // Duty floors at 1 so the tone never goes silent mid-pass
  assign decayed  = duty - (duty >> DECAY_SHIFT);
  assign duty_dec = (decayed == '0) ? ONE : decayed;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      counter  <= '0;
      stage    <= '0;
      pass     <= '0;
      duty     <= DUTY_INIT;
      wave_out <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_nx;
      counter  <= counter_nx;
      stage    <= stage_nx;
      pass     <= pass_nx;
      duty     <= duty_nx;
      wave_out <= wave_nx;
      busy     <= busy_nx;
      done     <= done_nx;
    end
  end

  // Abort beats trigger; trigger restarts from any state
  always_comb begin
    state_nx   = state;
    counter_nx = counter;
    stage_nx   = stage;
    pass_nx    = pass;
    duty_nx    = duty;
    if (abort) begin
      state_nx   = IDLE;
      counter_nx = '0;
      stage_nx   = '0;
      pass_nx    = '0;
      duty_nx    = DUTY_INIT;
    end else if (trigger) begin
      state_nx   = PLAY;
      counter_nx = '0;
      stage_nx   = '0;
      pass_nx    = '0;
      duty_nx    = DUTY_INIT;
    end else begin
      case (state)
        PLAY: begin
          if (counter == PERIOD_LAST) begin
            counter_nx = '0;
            if (stage == STAGE_LAST) begin
              stage_nx = '0;
              duty_nx  = DUTY_INIT;
              if (pass == PASS_LAST) begin
                state_nx = DONE;
                pass_nx  = '0;
              end else begin
                pass_nx = pass + 4'd1;
              end
            end else begin
              stage_nx = stage + 8'd1;
              duty_nx  = duty_dec;
            end
          end else begin
            counter_nx = counter + ONE;
          end
        end
        default: begin
          state_nx   = IDLE;
          counter_nx = '0;
          stage_nx   = '0;
          pass_nx    = '0;
          duty_nx    = DUTY_INIT;
        end
      endcase
    end
  end

  // Outputs are registered from the next-state values so they line up with them
  always_comb begin
    busy_nx = (state_nx == PLAY);
    done_nx = (state_nx == DONE);
    wave_nx = (state_nx == PLAY) && (counter_nx < duty_nx);
  end

endmodule

// File: tb/tb_decay_tone_player.sv
// Self-checking bench: three configurations driven in lockstep against a
// time-since-trigger reference model plus directed scenario checks.
module tb_decay_tone_player;

  localparam int P = 10;
  localparam int S = 4;
  localparam int R = 2;
  localparam int N = P * S * R;

  logic clk;
  logic rst_n;
  logic trigger;
  logic abort;
  logic wave_o [3];
  logic busy_o [3];
  logic done_o [3];

  int d0 [3] = '{8, 3, 1};
  int sh [3] = '{1, 2, 1};

  bit m_active [3];
  int m_t      [3];
  bit m_done   [3];

  int compared;
  int mismatched;

  decay_tone_player #(.PERIOD_W(8), .PERIOD(P), .STAGES(S), .REPEATS(R),
                      .DUTY0(8), .DECAY_SHIFT(1)) dut0 (
    .clk(clk), .rst_n(rst_n), .trigger(trigger), .abort(abort),
    .wave_out(wave_o[0]), .busy(busy_o[0]), .done(done_o[0]));

  decay_tone_player #(.PERIOD_W(8), .PERIOD(P), .STAGES(S), .REPEATS(R),
                      .DUTY0(3), .DECAY_SHIFT(2)) dut1 (
    .clk(clk), .rst_n(rst_n), .trigger(trigger), .abort(abort),
    .wave_out(wave_o[1]), .busy(busy_o[1]), .done(done_o[1]));

  decay_tone_player #(.PERIOD_W(8), .PERIOD(P), .STAGES(S), .REPEATS(R),
                      .DUTY0(1), .DECAY_SHIFT(1)) dut2 (
    .clk(clk), .rst_n(rst_n), .trigger(trigger), .abort(abort),
    .wave_out(wave_o[2]), .busy(busy_o[2]), .done(done_o[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Duty of a given stage: repeated decay from DUTY0, never below 1
  function automatic int refDuty(int i, int stg);
    int d;
    d = d0[i];
    for (int k = 0; k < stg; k++) begin
      d = d - (d >> sh[i]);
      if (d < 1) d = 1;
    end
    return d;
  endfunction

  task automatic checkOutput(input string tag, input int observed, input int expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s observed=%0d expected=%0d at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic modelStep(input bit trig, input bit abrt);
    for (int i = 0; i < 3; i++) begin
      if (!rst_n) begin
        m_active[i] = 0; m_t[i] = 0; m_done[i] = 0;
      end else if (abrt) begin
        m_active[i] = 0; m_t[i] = 0; m_done[i] = 0;
      end else if (trig) begin
        m_active[i] = 1; m_t[i] = 0; m_done[i] = 0;
      end else if (m_active[i]) begin
        m_t[i]++;
        if (m_t[i] == N) begin
          m_active[i] = 0; m_done[i] = 1;
        end
      end else begin
        m_done[i] = 0;
      end
    end
  endtask

  task automatic checkAll();
    int ew;
    for (int i = 0; i < 3; i++) begin
      ew = (m_active[i] && ((m_t[i] % P) < refDuty(i, (m_t[i] / P) % S))) ? 1 : 0;
      checkOutput($sformatf("wave%0d", i), int'(wave_o[i]), ew);
      checkOutput($sformatf("busy%0d", i), int'(busy_o[i]), int'(m_active[i]));
      checkOutput($sformatf("done%0d", i), int'(done_o[i]), int'(m_done[i]));
    end
  endtask

  // Drive inputs, take one clock edge, advance the model and compare
  task automatic applyStimulus(input bit trig, input bit abrt);
    trigger = trig;
    abort   = abrt;
    @(posedge clk);
    modelStep(trig, abrt);
    #1;
    checkAll();
    trigger = 1'b0;
    abort   = 1'b0;
  endtask

  int hi [3][8];
  int exp_hi [3][8] = '{'{8, 4, 2, 1, 8, 4, 2, 1},
                        '{3, 3, 3, 3, 3, 3, 3, 3},
                        '{1, 1, 1, 1, 1, 1, 1, 1}};
  int busy_cnt;
  int done_cnt;
  int run_len;
  bit seen;

  initial begin
    compared   = 0;
    mismatched = 0;
    trigger    = 1'b0;
    abort      = 1'b0;
    rst_n      = 1'b0;
    for (int i = 0; i < 3; i++) begin
      m_active[i] = 0; m_t[i] = 0; m_done[i] = 0;
    end
    applyStimulus(0, 0);
    applyStimulus(0, 0);
    rst_n = 1'b1;
    applyStimulus(0, 0);

    // Single trigger: per-period high times, busy length, done pulse
    for (int i = 0; i < 3; i++)
      for (int k = 0; k < 8; k++) hi[i][k] = 0;
    busy_cnt = 0;
    applyStimulus(1, 0);
    for (int c = 0; c < N; c++) begin
      for (int i = 0; i < 3; i++) hi[i][c / P] += int'(wave_o[i]);
      busy_cnt += int'(busy_o[0]);
      applyStimulus(0, 0);
    end
    checkOutput("single_done", int'(done_o[0]), 1);
    for (int i = 0; i < 3; i++)
      for (int k = 0; k < 8; k++)
        checkOutput($sformatf("hightime%0d_p%0d", i, k), hi[i][k], exp_hi[i][k]);
    checkOutput("single_busy_len", busy_cnt, N);
    applyStimulus(0, 0);
    checkOutput("single_idle_busy", int'(busy_o[0]), 0);
    for (int c = 0; c < 5; c++) applyStimulus(0, 0);

    // Retrigger at cycle 25
    applyStimulus(1, 0);
    for (int c = 0; c < 24; c++) applyStimulus(0, 0);
    applyStimulus(1, 0);
    checkOutput("retrig_wave", int'(wave_o[0]), 1);
    run_len  = 0;
    done_cnt = 0;
    seen     = 0;
    for (int c = 0; c < 120; c++) begin
      if (busy_o[0] && !seen) run_len++;
      else seen = 1;
      done_cnt += int'(done_o[0]);
      applyStimulus(0, 0);
    end
    checkOutput("retrig_busy_len", run_len, N);
    checkOutput("retrig_done_cnt", done_cnt, 1);

    // Abort at cycle 13, then trigger together with abort
    applyStimulus(1, 0);
    for (int c = 0; c < 12; c++) applyStimulus(0, 0);
    applyStimulus(0, 1);
    checkOutput("abort_busy", int'(busy_o[0]), 0);
    for (int c = 0; c < 3; c++) applyStimulus(0, 0);
    applyStimulus(1, 0);
    for (int c = 0; c < 5; c++) applyStimulus(0, 0);
    applyStimulus(1, 1);
    checkOutput("trigabort_wave", int'(wave_o[0]), 0);
    for (int c = 0; c < 5; c++) applyStimulus(0, 0);

    // Reset asserted mid-effect: outputs clear before the next edge
    applyStimulus(1, 0);
    for (int c = 0; c < 20; c++) applyStimulus(0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      checkOutput($sformatf("async_busy%0d", i), int'(busy_o[i]), 0);
      checkOutput($sformatf("async_wave%0d", i), int'(wave_o[i]), 0);
      checkOutput($sformatf("async_done%0d", i), int'(done_o[i]), 0);
    end
    for (int c = 0; c < 3; c++) applyStimulus(0, 0);
    rst_n = 1'b1;
    for (int c = 0; c < 10; c++) applyStimulus(0, 0);

    // Trigger sampled during the DONE cycle
    applyStimulus(1, 0);
    seen = 0;
    for (int c = 0; c < 2 * N && !seen; c++) begin
      applyStimulus(0, 0);
      if (done_o[0]) seen = 1;
    end
    checkOutput("done_reached", int'(seen), 1);
    applyStimulus(1, 0);
    checkOutput("done_retrig_busy", int'(busy_o[0]), 1);
    for (int c = 0; c < 10; c++) applyStimulus(0, 0);

    // Randomized trigger/abort traffic
    for (int c = 0; c < 600; c++)
      applyStimulus($urandom_range(0, 99) == 0, $urandom_range(0, 149) == 0);
    for (int c = 0; c < N + 5; c++) applyStimulus(0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
